// File: rtl/srmem_feeder.sv
// srmem_feeder: skid-buffered burst feeder that turns a ready/valid mask stream into single-cycle memory writes.
// Build option SRFEED_PAD_EN: zero-pad bursts shorter than CAP so every burst delivers exactly CAP writes.
module srmem_feeder #(
    parameter int unsigned NUM_RDPORT = 1,
    parameter int unsigned LEN_SRMEM  = 4,
    parameter int unsigned DATA_BW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_BW-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               valid_din,
    output logic [DATA_BW-1:0] din,
    output logic               is_lastdin,
    input  logic               wrfull,
    input  logic               wrend,
    output logic               busy,
    output logic               ovf
);
    localparam int unsigned       CAP      = NUM_RDPORT * LEN_SRMEM;
    localparam int unsigned       CNT_BW   = $clog2(CAP) + 1;
    localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(CAP - 1);
    localparam logic [CNT_BW-1:0] CNT_MAX  = CNT_BW'(CAP);

`ifdef SRFEED_PAD_EN
    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DROP, S_WAIT_END, S_PAD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DROP, S_WAIT_END} state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_BW-1:0] r_data0;
    logic [DATA_BW-1:0] r_data1;
    logic               r_last0;
    logic               r_last1;
    logic [1:0]         r_occ;
    logic [1:0]         w_occ_nxt;
    logic [CNT_BW-1:0]  r_cnt;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_got_last;

    logic               w_xfer;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_cnt_clr;
    logic               w_ovf_set;
    logic               w_ovf_clr;
    logic               w_end;
    logic               w_valid_din;
    logic               w_is_last;
    logic [DATA_BW-1:0] w_din;
    logic               w_got_last_nxt;
    logic               w_ready_nxt;

    assign w_xfer = in_valid & r_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, write issue and skid control
    always_comb begin
        w_state_nxt = r_state;
        w_valid_din = 1'b0;
        w_din       = '0;
        w_is_last   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_ovf_set   = 1'b0;
        w_ovf_clr   = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_push      = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_ovf_clr   = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                w_push = w_xfer;
                if (r_occ != 2'd0 && !wrfull) begin
                    w_valid_din = 1'b1;
                    w_pop       = 1'b1;
                    w_din       = r_data0;
                    if (r_cnt == CNT_LAST && !r_last0) begin
                        // Capacity reached mid-burst: the rest of the burst is discarded
                        w_is_last   = 1'b1;
                        w_ovf_set   = 1'b1;
                        w_flush     = 1'b1;
                        w_push      = 1'b0;
                        w_state_nxt = (r_got_last || (w_xfer && in_last)) ? S_WAIT_END : S_DROP;
                    end else if (r_last0) begin
`ifdef SRFEED_PAD_EN
                        if (r_cnt == CNT_LAST) begin
                            w_is_last   = 1'b1;
                            w_state_nxt = S_WAIT_END;
                        end else begin
                            w_state_nxt = S_PAD;
                        end
`else
                        w_is_last   = 1'b1;
                        w_state_nxt = S_WAIT_END;
`endif
                    end
                end
            end
            S_DROP: begin
                if (w_xfer && in_last) begin
                    w_state_nxt = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (wrend) begin
                    w_cnt_clr   = 1'b1;
                    w_end       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef SRFEED_PAD_EN
            S_PAD: begin
                if (!wrfull) begin
                    w_valid_din = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_is_last   = 1'b1;
                        w_state_nxt = S_WAIT_END;
                    end
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Occupancy and registered ready look-ahead
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_flush) begin
            w_occ_nxt = 2'd0;
        end else if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + 2'd1;
        end else if (!w_push && w_pop) begin
            w_occ_nxt = r_occ - 2'd1;
        end
        w_got_last_nxt = w_end ? 1'b0 : (r_got_last | (w_xfer & in_last));
        w_ready_nxt    = !w_got_last_nxt &&
                         ((w_state_nxt == S_IDLE) || (w_state_nxt == S_DROP) ||
                          ((w_state_nxt == S_STREAM) && (w_occ_nxt != 2'd2)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ      <= 2'd0;
            r_data0    <= '0;
            r_data1    <= '0;
            r_last0    <= 1'b0;
            r_last1    <= 1'b0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_got_last <= 1'b0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_in_ready <= w_ready_nxt;
            r_got_last <= w_got_last_nxt;
            if (!w_flush) begin
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_occ == 2'd0) begin
                            r_data0 <= in_data;
                            r_last0 <= in_last;
                        end else begin
                            r_data1 <= in_data;
                            r_last1 <= in_last;
                        end
                    end
                    2'b01: begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                    end
                    2'b11: begin
                        if (r_occ == 2'd1) begin
                            r_data0 <= in_data;
                            r_last0 <= in_last;
                        end else begin
                            r_data0 <= r_data1;
                            r_last0 <= r_last1;
                            r_data1 <= in_data;
                            r_last1 <= in_last;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_valid_din && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_BW'(1);
            end
            if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign valid_din  = w_valid_din;
    assign din        = w_din;
    assign is_lastdin = w_is_last;
    assign busy       = (r_state != S_IDLE);
    assign ovf        = r_ovf;

endmodule
